// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the datapath and mem_responder.
// master: Read, Write, MAR, MDRdata out; slave: Mdatain, MemDone, Busy, MemErr out.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Read;
    logic                  Write;
    logic [31:0]           MAR;
    logic [DATA_WIDTH-1:0] MDRdata;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  MemDone;
    logic                  Busy;
    logic                  MemErr;

    modport master (
        output Read,
        output Write,
        output MAR,
        output MDRdata,
        input  Mdatain,
        input  MemDone,
        input  Busy,
        input  MemErr
    );

    modport slave (
        input  Read,
        input  Write,
        input  MAR,
        input  MDRdata,
        output Mdatain,
        output MemDone,
        output Busy,
        output MemErr
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed synchronous RAM with configurable wait states.
// Ports: Clock, Clear (sync, active-high), bus (mem_responder_if.slave).
// Optional macro MEM_CONFLICT_ERR_EN: Read&Write at accept flags MemErr.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic            Clock,
    input  logic            Clear,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    conf_hit;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req_d;
    logic                    accept_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    unused_mar_hi;

    assign req_d    = bus.Read | bus.Write;
    assign accept_d = (state_q == S_IDLE) && req_d;
    assign addr_d   = bus.MAR[ADDR_WIDTH-1:0];
    // Upper MAR bits alias onto the low word address.
    assign unused_mar_hi = ^bus.MAR[31:ADDR_WIDTH];

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        addr_q  <= addr_d;
                        wdata_q <= bus.MDRdata;
                        // Read wins over a simultaneous write.
                        we_q    <= bus.Write & ~bus.Read;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == LAST_WAIT) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RESP: begin
                    if (!we_q && !conf_hit) begin
                        rdata_q <= mem[addr_q];
                    end
                    done_q  <= 1'b1;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    done_q <= 1'b0;
                    // Wait for strobes to drop so a held level can't retrigger.
                    if (!req_d) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // RAM contents survive Clear; Clear on the commit edge aborts the write.
    always_ff @(posedge Clock) begin
        if (!Clear && state_q == S_RESP && we_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

`ifdef MEM_CONFLICT_ERR_EN
    logic conf_q;
    logic err_q;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            conf_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept_d) begin
                conf_q <= bus.Read & bus.Write;
            end
            // Pulses alongside MemDone.
            err_q <= (state_q == S_RESP) && conf_q;
        end
    end

    assign conf_hit   = conf_q;
    assign bus.MemErr = err_q;
`else
    logic unused_accept;

    assign unused_accept = accept_d;
    assign conf_hit      = 1'b0;
    assign bus.MemErr    = 1'b0;
`endif

    assign bus.Mdatain = rdata_q;
    assign bus.MemDone = done_q;
    assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: three responders (0, 1, 3 wait states) share stimulus.
// Expected responses are queued per instance and checked by monitors.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] mar = '0;
    logic [31:0] mdr = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if b0 ();
    mem_responder_if b1 ();
    mem_responder_if b3 ();

    assign b0.Read = rd;  assign b0.Write = wr;
    assign b0.MAR = mar;  assign b0.MDRdata = mdr;
    assign b1.Read = rd;  assign b1.Write = wr;
    assign b1.MAR = mar;  assign b1.MDRdata = mdr;
    assign b3.Read = rd;  assign b3.Write = wr;
    assign b3.MAR = mar;  assign b3.MDRdata = mdr;

    mem_responder #(.WAIT_STATES(0)) d0 (.Clock(clk), .Clear(clr), .bus(b0));
    mem_responder #(.WAIT_STATES(1)) d1 (.Clock(clk), .Clear(clr), .bus(b1));
    mem_responder #(.WAIT_STATES(3)) d3 (.Clock(clk), .Clear(clr), .bus(b3));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          acc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] ref_mem [512];
    logic [31:0] last_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input int ws, input exp_t e,
                       input logic [31:0] d, input logic er);
        chk($sformatf("ws%0d data", ws), d, e.d);
        chk($sformatf("ws%0d err", ws), 32'(er), 32'(e.e));
        chk($sformatf("ws%0d latency", ws), 32'(cyc - e.acc), 32'(ws + 1));
    endtask

    always @(negedge clk) begin
        if (b0.MemDone) begin
            if (q0.size() == 0) chk("ws0 spurious done", 32'(b0.MemDone), 0);
            else cmp(0, q0.pop_front(), b0.Mdatain, b0.MemErr);
        end else chk("ws0 err idle", 32'(b0.MemErr), 0);
    end
    always @(negedge clk) begin
        if (b1.MemDone) begin
            if (q1.size() == 0) chk("ws1 spurious done", 32'(b1.MemDone), 0);
            else cmp(1, q1.pop_front(), b1.Mdatain, b1.MemErr);
        end else chk("ws1 err idle", 32'(b1.MemErr), 0);
    end
    always @(negedge clk) begin
        if (b3.MemDone) begin
            if (q3.size() == 0) chk("ws3 spurious done", 32'(b3.MemDone), 0);
            else cmp(3, q3.pop_front(), b3.Mdatain, b3.MemErr);
        end else chk("ws3 err idle", 32'(b3.MemErr), 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit any_busy();
        return b0.Busy | b1.Busy | b3.Busy;
    endfunction

    function automatic bit pending();
        return (q0.size() + q1.size() + q3.size()) != 0;
    endfunction

    task automatic chk_busy(input string nm, input logic v);
        chk({nm, " ws0"}, 32'(b0.Busy), 32'(v));
        chk({nm, " ws1"}, 32'(b1.Busy), 32'(v));
        chk({nm, " ws3"}, 32'(b3.Busy), 32'(v));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!any_busy()) return;
            step();
        end
        chk("idle timeout", 32'(any_busy()), 0);
    endtask

    // One transaction; the model computes the response from the ops alone.
    task automatic req(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input bit early);
        exp_t e;
        int   n;
        logic [8:0] wa;
        wait_idle();
        wa = a[8:0];
        rd = r; wr = w; mar = a; mdr = d;
        e.e = 1'b0;
        if (r && w) begin
`ifdef MEM_CONFLICT_ERR_EN
            e.d = last_rd;
            e.e = 1'b1;
`else
            e.d = ref_mem[wa];
            last_rd = e.d;
`endif
        end else if (r) begin
            e.d = ref_mem[wa];
            last_rd = e.d;
        end else begin
            ref_mem[wa] = d;
            e.d = last_rd;
        end
        e.acc = cyc + 1;
        q0.push_back(e); q1.push_back(e); q3.push_back(e);
        step();
        if (early) begin rd = 1'b0; wr = 1'b0; end
        n = 0;
        while (pending() && n < 40) begin
            mar = $urandom; mdr = $urandom;
            step();
            n++;
        end
        if (pending()) begin
            chk("done timeout", 32'(pending()), 0);
            q0.delete(); q1.delete(); q3.delete();
        end
        for (int i = 0; i < hold; i++) begin
            if (!early) chk_busy("held busy", 1'b1);
            step();
        end
        rd = 1'b0; wr = 1'b0;
        step();
        chk_busy("busy after drop", 1'b0);
    endtask

    initial begin
        repeat (2) step();
        chk("rst data ws0", b0.Mdatain, 0);
        chk("rst done ws1", 32'(b1.MemDone), 0);
        chk("rst err ws3", 32'(b3.MemErr), 0);
        chk_busy("rst busy", 1'b0);
        clr = 1'b0;
        step();

        for (int a = 0; a < 512; a++) begin
            req(1'b0, 1'b1, 32'(a), (a == 32'h20) ? 32'h0 : $urandom, 0, 1'b0);
        end

        req(1'b0, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 0, 1'b0);
        req(1'b1, 1'b0, 32'h0000_0012, 32'h0, 0, 1'b0);
        chk("read deadbeef", b1.Mdatain, 32'hDEAD_BEEF);
        req(1'b1, 1'b0, 32'h0000_0005, 32'h0, 10, 1'b0);
        req(1'b1, 1'b1, 32'h0000_0012, 32'h0, 0, 1'b0);
        req(1'b1, 1'b0, 32'h0000_0012, 32'h0, 0, 1'b0);
        chk("conflict kept ram", b3.Mdatain, 32'hDEAD_BEEF);

        req(1'b0, 1'b1, 32'h0000_0007, 32'h0000_0001, 0, 1'b0);
        req(1'b1, 1'b0, 32'h0000_0007, 32'h0, 0, 1'b1);

        wait_idle();
        wr = 1'b1; mar = 32'h20; mdr = 32'hAAAA_5555;
        step();
        wr = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        last_rd = '0;
        chk("clr data ws0", b0.Mdatain, 0);
        chk("clr data ws1", b1.Mdatain, 0);
        chk("clr data ws3", b3.Mdatain, 0);
        chk_busy("clr busy", 1'b0);
        repeat (5) step();
        req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);

        req(1'b0, 1'b1, 32'h0000_0212, 32'h1234_5678, 0, 1'b0);
        req(1'b1, 1'b0, 32'h0000_0012, 32'h0, 0, 1'b0);
        chk("alias read", b0.Mdatain, 32'h1234_5678);

        for (int i = 0; i < 300; i++) begin
            int t;
            t = $urandom_range(0, 9);
            req(t < 4 || t > 7, t > 3, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
